// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control sequencer for the multicycle RV32I core
module multicycle_control_fsm #(
    parameter bit ENABLE_JUMPS    = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] instruction_opcode,
    input  logic       memory_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       lorD,
    output logic       memory_read,
    output logic       memory_write,
    output logic       ir_write,
    output logic [1:0] memory_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       illegal_instruction,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JAL       = 4'd9,
        S_JALR      = 4'd10,
        S_UPPER     = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Where an unrecognised opcode sends the machine: sticky trap or silent NOP.
    localparam state_t ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

    state_t state_q, state_d;

    // Next-state decode; memory waits hold the state until memory_ready.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = memory_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (instruction_opcode)
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_RTYPE, OP_ITYPE: state_d = S_EXECUTE;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = ENABLE_JUMPS ? S_JAL : ILLEGAL_NEXT;
                    OP_JALR:            state_d = ENABLE_JUMPS ? S_JALR : ILLEGAL_NEXT;
                    OP_LUI, OP_AUIPC:   state_d = ENABLE_JUMPS ? S_UPPER : ILLEGAL_NEXT;
                    default:            state_d = ILLEGAL_NEXT;
                endcase
            end
            // Opcode bit 5 separates store (1) from load (0).
            S_MEM_ADDR:  state_d = instruction_opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = memory_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = memory_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_FETCH;
            S_JALR:      state_d = S_FETCH;
            S_UPPER:     state_d = S_ALU_WB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode; reset forces every output low regardless of state.
    always_comb begin
        pc_write            = 1'b0;
        pc_write_cond       = 1'b0;
        pc_source           = 2'b00;
        lorD                = 1'b0;
        memory_read         = 1'b0;
        memory_write        = 1'b0;
        ir_write            = 1'b0;
        memory_to_reg       = 2'b00;
        reg_write           = 1'b0;
        alu_src_a           = 2'b00;
        alu_src_b           = 2'b00;
        aluop               = 2'b00;
        illegal_instruction = 1'b0;
        state               = 4'd0;
        if (!reset) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    memory_read = 1'b1;
                    alu_src_b   = 2'b01;
                    ir_write    = memory_ready;
                    pc_write    = memory_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    memory_read = 1'b1;
                    lorD        = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write     = 1'b1;
                    memory_to_reg = 2'b01;
                end
                S_MEM_WRITE: begin
                    memory_write = 1'b1;
                    lorD         = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = instruction_opcode[5] ? 2'b00 : 2'b10;
                    aluop     = instruction_opcode[5] ? 2'b10 : 2'b11;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 2'b01;
                    aluop         = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JAL: begin
                    pc_write      = 1'b1;
                    pc_source     = 2'b01;
                    reg_write     = 1'b1;
                    memory_to_reg = 2'b10;
                end
                S_JALR: begin
                    alu_src_a     = 2'b01;
                    alu_src_b     = 2'b10;
                    pc_write      = 1'b1;
                    reg_write     = 1'b1;
                    memory_to_reg = 2'b10;
                end
                S_UPPER: begin
                    // LUI adds to zero, AUIPC adds to the old PC.
                    alu_src_a = instruction_opcode[5] ? 2'b11 : 2'b10;
                    alu_src_b = 2'b10;
                end
                S_TRAP: begin
                    illegal_instruction = 1'b1;
                end
                default: begin
                    state = state_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] instruction_opcode;
    logic       memory_ready;

    // Instance 0: jumps on, trap on. 1: jumps off, trap on. 2: jumps on, trap off.
    logic [2:0] pc_write, pc_write_cond, lorD, memory_read, memory_write;
    logic [2:0] ir_write, reg_write, illegal_instruction;
    logic [1:0] pc_source [3];
    logic [1:0] memory_to_reg [3];
    logic [1:0] alu_src_a [3];
    logic [1:0] alu_src_b [3];
    logic [1:0] aluop [3];
    logic [3:0] state [3];
    logic [21:0] obs [3];

    always #5 clk = ~clk;

    multicycle_control_fsm #(.ENABLE_JUMPS(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .instruction_opcode(instruction_opcode),
        .memory_ready(memory_ready), .pc_write(pc_write[0]), .pc_write_cond(pc_write_cond[0]),
        .pc_source(pc_source[0]), .lorD(lorD[0]), .memory_read(memory_read[0]),
        .memory_write(memory_write[0]), .ir_write(ir_write[0]), .memory_to_reg(memory_to_reg[0]),
        .reg_write(reg_write[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
        .aluop(aluop[0]), .illegal_instruction(illegal_instruction[0]), .state(state[0]));

    multicycle_control_fsm #(.ENABLE_JUMPS(1'b0), .TRAP_ON_ILLEGAL(1'b1)) dut_nj (
        .clk(clk), .reset(reset), .instruction_opcode(instruction_opcode),
        .memory_ready(memory_ready), .pc_write(pc_write[1]), .pc_write_cond(pc_write_cond[1]),
        .pc_source(pc_source[1]), .lorD(lorD[1]), .memory_read(memory_read[1]),
        .memory_write(memory_write[1]), .ir_write(ir_write[1]), .memory_to_reg(memory_to_reg[1]),
        .reg_write(reg_write[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
        .aluop(aluop[1]), .illegal_instruction(illegal_instruction[1]), .state(state[1]));

    multicycle_control_fsm #(.ENABLE_JUMPS(1'b1), .TRAP_ON_ILLEGAL(1'b0)) dut_nt (
        .clk(clk), .reset(reset), .instruction_opcode(instruction_opcode),
        .memory_ready(memory_ready), .pc_write(pc_write[2]), .pc_write_cond(pc_write_cond[2]),
        .pc_source(pc_source[2]), .lorD(lorD[2]), .memory_read(memory_read[2]),
        .memory_write(memory_write[2]), .ir_write(ir_write[2]), .memory_to_reg(memory_to_reg[2]),
        .reg_write(reg_write[2]), .alu_src_a(alu_src_a[2]), .alu_src_b(alu_src_b[2]),
        .aluop(aluop[2]), .illegal_instruction(illegal_instruction[2]), .state(state[2]));

    // Packing: state, pc_write, pc_write_cond, pc_source, lorD, memory_read, memory_write,
    // ir_write, memory_to_reg, reg_write, alu_src_a, alu_src_b, aluop, illegal_instruction
    for (genvar g = 0; g < 3; g++) begin : g_obs
        assign obs[g] = {state[g], pc_write[g], pc_write_cond[g], pc_source[g], lorD[g],
                         memory_read[g], memory_write[g], ir_write[g], memory_to_reg[g],
                         reg_write[g], alu_src_a[g], alu_src_b[g], aluop[g], illegal_instruction[g]};
    end

    localparam logic [21:0] X_ZERO      = 22'd0;
    localparam logic [21:0] X_FETCH_RDY = {4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [21:0] X_FETCH_WT  = {4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [21:0] X_DECODE    = {4'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [21:0] X_MEM_ADDR  = {4'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0};
    localparam logic [21:0] X_MEM_READ  = {4'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [21:0] X_MEM_WB    = {4'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [21:0] X_MEM_WRITE = {4'd5, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [21:0] X_EXEC_R    = {4'd6, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 2'b10, 1'b0};
    localparam logic [21:0] X_EXEC_I    = {4'd6, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b10, 2'b11, 1'b0};
    localparam logic [21:0] X_ALU_WB    = {4'd7, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [21:0] X_BRANCH    = {4'd8, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 2'b01, 1'b0};
    localparam logic [21:0] X_JAL       = {4'd9, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [21:0] X_JALR      = {4'd10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 2'b10, 2'b00, 1'b0};
    localparam logic [21:0] X_LUI       = {4'd11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 2'b10, 2'b00, 1'b0};
    localparam logic [21:0] X_AUIPC     = {4'd11, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0};
    localparam logic [21:0] X_TRAP      = {4'd12, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};

    int checks = 0;
    int errors = 0;

    // Scoreboard: per-cycle stimulus and the expected observation for that cycle.
    bit          rst_q [$];
    bit          rdy_q [$];
    logic [21:0] exp_q [$];

    task automatic push(input bit r, input bit m, input logic [21:0] e);
        rst_q.push_back(r);
        rdy_q.push_back(m);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [21:0] e;
        int n = 0;
        instruction_opcode = 7'b0110011;
        repeat (3) push(1'b1, 1'b1, X_ZERO);
        push(1'b0, 1'b1, X_FETCH_RDY);
        push(1'b0, 1'b1, X_DECODE);
        push(1'b0, 1'b1, X_EXEC_R);
        push(1'b0, 1'b1, X_ALU_WB);
        push(1'b0, 1'b1, X_FETCH_RDY);
        while (exp_q.size() > 0) begin
            reset = rst_q.pop_front(); memory_ready = rdy_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            checks++;
            if (obs[0] !== e) begin
                errors++;
                $display("FAIL reset_rtype cycle %0d: got %h expected %h", n, obs[0], e);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_load_wait();
        logic [21:0] e;
        int n = 0;
        instruction_opcode = 7'b0000011;
        push(1'b1, 1'b1, X_ZERO);
        push(1'b0, 1'b1, X_FETCH_RDY);
        push(1'b0, 1'b0, X_DECODE);
        push(1'b0, 1'b0, X_MEM_ADDR);
        push(1'b0, 1'b0, X_MEM_READ);
        push(1'b0, 1'b0, X_MEM_READ);
        push(1'b0, 1'b1, X_MEM_READ);
        push(1'b0, 1'b0, X_MEM_WB);
        push(1'b0, 1'b0, X_FETCH_WT);
        while (exp_q.size() > 0) begin
            reset = rst_q.pop_front(); memory_ready = rdy_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            checks++;
            if (obs[0] !== e) begin
                errors++;
                $display("FAIL load_wait cycle %0d: got %h expected %h", n, obs[0], e);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_store_fetch_wait();
        logic [21:0] e;
        int n = 0;
        instruction_opcode = 7'b0100011;
        push(1'b1, 1'b0, X_ZERO);
        push(1'b0, 1'b0, X_FETCH_WT);
        push(1'b0, 1'b1, X_FETCH_RDY);
        push(1'b0, 1'b1, X_DECODE);
        push(1'b0, 1'b1, X_MEM_ADDR);
        push(1'b0, 1'b1, X_MEM_WRITE);
        push(1'b0, 1'b1, X_FETCH_RDY);
        while (exp_q.size() > 0) begin
            reset = rst_q.pop_front(); memory_ready = rdy_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            checks++;
            if (obs[0] !== e) begin
                errors++;
                $display("FAIL store_fetch_wait cycle %0d: got %h expected %h", n, obs[0], e);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_other_types();
        logic [21:0] e;
        int n = 0;
        logic [6:0] ops [6];
        logic [21:0] mid [6];
        ops = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0110111, 7'b0010111};
        mid = '{X_BRANCH, X_JAL, X_JALR, X_EXEC_I, X_LUI, X_AUIPC};
        for (int k = 0; k < 6; k++) begin
            instruction_opcode = ops[k];
            push(1'b1, 1'b1, X_ZERO);
            push(1'b0, 1'b1, X_FETCH_RDY);
            push(1'b0, 1'b0, X_DECODE);
            push(1'b0, 1'b0, mid[k]);
            if (k >= 3) push(1'b0, 1'b1, X_ALU_WB);
            push(1'b0, 1'b1, X_FETCH_RDY);
            while (exp_q.size() > 0) begin
                reset = rst_q.pop_front(); memory_ready = rdy_q.pop_front(); e = exp_q.pop_front();
                @(negedge clk);
                checks++;
                if (obs[0] !== e) begin
                    errors++;
                    $display("FAIL opcode_%b cycle %0d: got %h expected %h", ops[k], n, obs[0], e);
                end
                @(posedge clk); #1; n++;
            end
        end
    endtask

    task automatic test_trap_jumps_disabled();
        logic [21:0] e;
        int n = 0;
        instruction_opcode = 7'b1101111;
        push(1'b1, 1'b1, X_ZERO);
        push(1'b0, 1'b1, X_FETCH_RDY);
        push(1'b0, 1'b1, X_DECODE);
        for (int i = 0; i < 10; i++) push(1'b0, i[0], X_TRAP);
        push(1'b1, 1'b1, X_ZERO);
        push(1'b0, 1'b0, X_FETCH_WT);
        while (exp_q.size() > 0) begin
            reset = rst_q.pop_front(); memory_ready = rdy_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            checks++;
            if (obs[1] !== e) begin
                errors++;
                $display("FAIL trap_no_jumps cycle %0d: got %h expected %h", n, obs[1], e);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_illegal_nop();
        logic [21:0] e;
        int n = 0;
        instruction_opcode = 7'b1111111;
        push(1'b1, 1'b1, X_ZERO);
        push(1'b0, 1'b1, X_FETCH_RDY);
        push(1'b0, 1'b1, X_DECODE);
        push(1'b0, 1'b1, X_FETCH_RDY);
        push(1'b0, 1'b1, X_DECODE);
        push(1'b0, 1'b0, X_FETCH_WT);
        while (exp_q.size() > 0) begin
            reset = rst_q.pop_front(); memory_ready = rdy_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            checks++;
            if (obs[2] !== e) begin
                errors++;
                $display("FAIL illegal_nop cycle %0d: got %h expected %h", n, obs[2], e);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset_in_mem_wait();
        logic [21:0] e;
        int n = 0;
        instruction_opcode = 7'b0100011;
        push(1'b1, 1'b1, X_ZERO);
        push(1'b0, 1'b1, X_FETCH_RDY);
        push(1'b0, 1'b1, X_DECODE);
        push(1'b0, 1'b1, X_MEM_ADDR);
        push(1'b0, 1'b0, X_MEM_WRITE);
        push(1'b0, 1'b0, X_MEM_WRITE);
        push(1'b1, 1'b0, X_ZERO);
        push(1'b0, 1'b0, X_FETCH_WT);
        while (exp_q.size() > 0) begin
            reset = rst_q.pop_front(); memory_ready = rdy_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk);
            checks++;
            if (obs[0] !== e) begin
                errors++;
                $display("FAIL reset_in_mem_write cycle %0d: got %h expected %h", n, obs[0], e);
            end
            @(posedge clk); #1; n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        memory_ready = 1'b0;
        instruction_opcode = 7'd0;
        test_reset();
        test_load_wait();
        test_store_fetch_wait();
        test_other_types();
        test_trap_jumps_disabled();
        test_illegal_nop();
        test_reset_in_mem_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Sequential control unit for the multicycle RV32I core. It replaces the purely opcode-decoded control block with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles. It waits on a memory-ready handshake and adds JAL/JALR/LUI/AUIPC sequencing and illegal-opcode trapping. It sits between the instruction register (opcode source) and the datapath muxes, register file, PC and memory interface.

## Interface
- ENABLE_JUMPS, 1: 1 = JAL/JALR/LUI/AUIPC supported; 0 = those opcodes are illegal.
- TRAP_ON_ILLEGAL, 1: 1 = illegal opcode enters sticky TRAP; 0 = illegal opcode is a NOP (back to FETCH).
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- instruction_opcode  in  7  IR[6:0], stable from DECODE until the next FETCH.
- memory_ready  in  1  memory completed the requested read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (branch).
- pc_source  out  2  00 ALU result, 01 ALUOut register.
- lorD  out  1  memory address: 0 PC, 1 ALUOut.
- memory_read  out  1  memory read request.
- memory_write  out  1  memory write request.
- ir_write  out  1  IR load.
- memory_to_reg  out  2  writeback: 00 ALUOut, 01 MDR, 10 PC (= old PC + 4).
- reg_write  out  1  register file write.
- alu_src_a  out  2  00 PC, 01 rs1, 10 old PC, 11 zero.
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate.
- aluop  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct.
- illegal_instruction  out  1  high while in TRAP.
- state  out  4  current state encoding (debug).

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JAL 9, JALR 10, UPPER 11, TRAP 12. Encodings 13–15 → FETCH next cycle, all outputs 0.
- Any output not listed for a state is 0.
- FETCH:
  - memory_read=1, lorD=0, alu_src_a=00, alu_src_b=01, aluop=00.
  - Only when memory_ready=1: ir_write=1, pc_write=1, pc_source=00, and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=10, alu_src_b=10, aluop=00 (ALUOut ← old PC + imm). Next state by opcode:
  - 0000011 / 0100011 → MEM_ADDR.
  - 0110011 / 0010011 → EXECUTE.
  - 1100011 → BRANCH.
  - 1101111 → JAL; 1100111 → JALR; 0110111 / 0010111 → UPPER (only if ENABLE_JUMPS=1).
  - Else illegal → TRAP if TRAP_ON_ILLEGAL=1, otherwise FETCH.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, aluop=00. Load → MEM_READ; store → MEM_WRITE.
- MEM_READ: memory_read=1, lorD=1. memory_ready=1 → MEM_WB; else stay.
- MEM_WB: reg_write=1, memory_to_reg=01 → FETCH.
- MEM_WRITE: memory_write=1, lorD=1. memory_ready=1 → FETCH; else stay.
- EXECUTE: alu_src_a=01.
  - R-type: alu_src_b=00, aluop=10.
  - I-type: alu_src_b=10, aluop=11.
  - → ALU_WB.
- ALU_WB: reg_write=1, memory_to_reg=00 → FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, aluop=01, pc_write_cond=1, pc_source=01 → FETCH.
- JAL: pc_write=1, pc_source=01, reg_write=1, memory_to_reg=10 → FETCH.
- JALR: alu_src_a=01, alu_src_b=10, aluop=00, pc_write=1, pc_source=00, reg_write=1, memory_to_reg=10 → FETCH. The datapath clears bit 0.
- UPPER: alu_src_b=10, aluop=00 → ALU_WB.
  - alu_src_a=11 for LUI (opcode bit 5 = 1).
  - alu_src_a=10 for AUIPC.
- TRAP: illegal_instruction=1, all other outputs 0. Stays until reset.

## Timing
- Reset: state register ← FETCH on the rising edge with reset=1. While reset=1, all outputs are 0 and state=0, overriding the state decode.
- The first fetch request appears in the first cycle after reset deasserts.
- Outputs are combinational from the state register. Only FETCH ir_write/pc_write/pc_source depend on memory_ready; EXECUTE and UPPER mux selects depend on the opcode.
- Cycle counts with zero wait (memory_ready=1 whenever requested):
  - Load 5 (F, D, MA, MR, MWB).
  - Store 4.
  - R-type / I-type 4.
  - Branch 3.
  - JAL 3; JALR 3.
  - LUI/AUIPC 4.
- Each cycle with memory_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- memory_read / memory_write stay asserted, with lorD stable, until the cycle memory_ready=1.
- memory_ready is ignored in states with no memory request.
- Reset mid-instruction (including during a memory wait): abort at the next edge with no further writes. Outputs are 0 from the cycle reset is sampled high.

## Test plan
- Reset hold 3 cycles, release, memory_ready=1, opcode 0110011:
  - state sequence 0,1,6,7,0.
  - reg_write=1 only in state 7; aluop=10 in state 6.
- Load 0000011 with memory_ready low for 2 cycles in MEM_READ:
  - sequence 0,1,2,3,3,3,4,0.
  - memory_read=1 and lorD=1 through all three MEM_READ cycles.
  - memory_to_reg=01 in state 4.
- Store 0100011 with FETCH wait of 1 cycle:
  - ir_write=0 in the first FETCH cycle, 1 in the second.
  - memory_write=1 in state 5 for exactly one cycle.
- Branch 1100011: state 8 shows pc_write_cond=1, pc_source=01, aluop=01, alu_src_b=00; returns to FETCH next cycle.
- JAL 1101111 with ENABLE_JUMPS=1 → state 9 with pc_write=1, reg_write=1, memory_to_reg=10. Same opcode with ENABLE_JUMPS=0, TRAP_ON_ILLEGAL=1 → state 12, illegal_instruction stays 1 for 10 cycles, cleared by reset.
- Opcode 1111111 with TRAP_ON_ILLEGAL=0 → DECODE then FETCH, illegal_instruction stays 0. Reset asserted in MEM_WRITE during a wait → next state 0, memory_write=0 the same cycle.
